// File: rtl/sum_of_squares_seq_pkg.sv
// Shared definitions for the sum-of-squares accumulator and its square-root consumer.
package sum_of_squares_seq_pkg;

    localparam logic [1:0] STATE_IDLE = 2'b00;
    localparam logic [1:0] STATE_LOAD = 2'b01;
    localparam logic [1:0] STATE_MUL  = 2'b10;
    localparam logic [1:0] STATE_DONE = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = STATE_IDLE,
        ST_LOAD = STATE_LOAD,
        ST_MUL  = STATE_MUL,
        ST_DONE = STATE_DONE
    } state_e;

    // Ceiling log2; clog2(0) and clog2(1) both return 0.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned v;
        int unsigned res;
        res = 0;
        v   = (value > 0) ? value - 1 : 0;
        while (v != 0) begin
            v   = v >> 1;
            res = res + 1;
        end
        return res;
    endfunction

endpackage

// File: rtl/sum_of_squares_seq_sqr_shift_add_unit.sv
// W-cycle shift-add squarer: load captures the sample, each en cycle folds one
// multiplier bit into the running partial product.
module sqr_shift_add_unit
    import sum_of_squares_seq_pkg::*;
#(
    parameter int unsigned W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             en,
    input  logic [W-1:0]     din,
    output logic [2*W-1:0]   prod_next,
    output logic             last
);

    localparam int unsigned PW = 2 * W;
    localparam int unsigned BW = clog2(W + 1);

    logic [PW-1:0] r_mcand;
    logic [W-1:0]  r_mplier;
    logic [PW-1:0] r_prod;
    logic [BW-1:0] r_bitcnt;
    logic [PW-1:0] w_addend;

    always_comb begin
        w_addend = PW'(0);
        if (r_mplier[0]) begin
            w_addend = r_mcand;
        end
    end

    assign prod_next = r_prod + w_addend;
    // High on the W-th MUL cycle, when prod_next is the complete square.
    assign last      = (r_bitcnt == BW'(W - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mcand  <= PW'(0);
            r_mplier <= W'(0);
            r_prod   <= PW'(0);
            r_bitcnt <= BW'(0);
        end else if (load) begin
            r_mcand  <= PW'(din);
            r_mplier <= din;
            r_prod   <= PW'(0);
            r_bitcnt <= BW'(0);
        end else if (en) begin
            r_prod   <= prod_next;
            r_mcand  <= {r_mcand[PW-2:0], 1'b0};
            r_mplier <= r_mplier >> 1;
            r_bitcnt <= r_bitcnt + BW'(1);
        end
    end

endmodule

// File: rtl/sum_of_squares_seq.sv
// Accumulates the squares of L handshaked samples and emits the N-bit total
// with a one-cycle out_valid pulse, feeding a downstream square-root unit.
module sum_of_squares_seq
    import sum_of_squares_seq_pkg::*;
#(
    parameter int unsigned W = 4,
    parameter int unsigned L = 4,
    parameter int unsigned N = 10
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [W-1:0] in_data,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [N-1:0] out_data,
    output logic         out_valid,
    output logic         busy
);

    localparam int unsigned PW = 2 * W;
    localparam int unsigned CW = clog2(L + 1);

    if ((L < 1) || ((N % 2) != 0) || (N < PW + clog2(L))) begin : g_param_check
        $error("sum_of_squares_seq: need L >= 1, N even and N >= 2*W + clog2(L)");
    end

    state_e        r_state;
    state_e        w_state_nxt;
    logic [N-1:0]  r_acc;
    logic [N-1:0]  w_acc_nxt;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cnt_nxt;
    logic [N-1:0]  r_out_data;
    logic [N-1:0]  w_out_data_nxt;
    logic          r_out_valid;
    logic          w_out_valid_nxt;
    logic          w_sqr_load;
    logic          w_sqr_en;
    logic [PW-1:0] w_prod_next;
    logic          w_last;

    sqr_shift_add_unit #(
        .W (W)
    ) u_sqr (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (w_sqr_load),
        .en        (w_sqr_en),
        .din       (in_data),
        .prod_next (w_prod_next),
        .last      (w_last)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state, datapath updates and squarer control.
    always_comb begin
        w_state_nxt     = r_state;
        w_acc_nxt       = r_acc;
        w_cnt_nxt       = r_cnt;
        w_out_data_nxt  = r_out_data;
        w_out_valid_nxt = 1'b0;
        w_sqr_load      = 1'b0;
        w_sqr_en        = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_acc_nxt   = N'(0);
                    w_cnt_nxt   = CW'(0);
                    w_state_nxt = ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (in_valid) begin
                    w_sqr_load  = 1'b1;
                    w_state_nxt = ST_MUL;
                end
            end
            ST_MUL: begin
                w_sqr_en = 1'b1;
                // Final partial product goes straight into acc, saving a cycle per sample.
                if (w_last) begin
                    w_acc_nxt   = r_acc + N'(w_prod_next);
                    w_cnt_nxt   = r_cnt + CW'(1);
                    w_state_nxt = (r_cnt == CW'(L - 1)) ? ST_DONE : ST_LOAD;
                end
            end
            ST_DONE: begin
                w_out_data_nxt  = r_acc;
                w_out_valid_nxt = 1'b1;
                w_state_nxt     = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc       <= N'(0);
            r_cnt       <= CW'(0);
            r_out_data  <= N'(0);
            r_out_valid <= 1'b0;
        end else begin
            r_acc       <= w_acc_nxt;
            r_cnt       <= w_cnt_nxt;
            r_out_data  <= w_out_data_nxt;
            r_out_valid <= w_out_valid_nxt;
        end
    end

    assign in_ready  = (r_state == ST_LOAD);
    assign busy      = (r_state != ST_IDLE);
    assign out_data  = r_out_data;
    assign out_valid = r_out_valid;

endmodule

// File: tb/tb_sum_of_squares_seq.sv
// Bench for sum_of_squares_seq: a table of fixed vectors, hand-written reset and
// restart sequences, and random vectors against a sum-of-squares model.
module tb_sum_of_squares_seq;

    localparam int TW = 4;

    typedef struct packed {
        logic [15:0] s;
        logic [1:0]  gap;
        logic        noise;
        logic [9:0]  exp;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic       in_valid;
    logic [3:0] in_data;
    logic       sel2;

    logic       start1, start2, in_valid1, in_valid2;
    logic       in_ready1, in_ready2, out_valid1, out_valid2, busy1, busy2;
    logic [9:0] out_data1;
    logic [7:0] out_data2;
    logic       in_ready_m, out_valid_m, busy_m;
    logic [9:0] out_data_m;

    int n_pass   = 0;
    int n_total  = 0;
    int prev_out = 0;

    always #5 clk = ~clk;

    assign start1     = start & ~sel2;
    assign in_valid1  = in_valid & ~sel2;
    assign start2     = start & sel2;
    assign in_valid2  = in_valid & sel2;
    assign in_ready_m = sel2 ? in_ready2 : in_ready1;
    assign out_valid_m = sel2 ? out_valid2 : out_valid1;
    assign busy_m     = sel2 ? busy2 : busy1;
    assign out_data_m = sel2 ? {2'b00, out_data2} : out_data1;

    sum_of_squares_seq #(.W(4), .L(4), .N(10)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start1),
        .in_data   (in_data),
        .in_valid  (in_valid1),
        .in_ready  (in_ready1),
        .out_data  (out_data1),
        .out_valid (out_valid1),
        .busy      (busy1)
    );

    sum_of_squares_seq #(.W(4), .L(1), .N(8)) dut_l1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start2),
        .in_data   (in_data),
        .in_valid  (in_valid2),
        .in_ready  (in_ready2),
        .out_data  (out_data2),
        .out_valid (out_valid2),
        .busy      (busy2)
    );

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic do_start(input string name);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk({name, "_ready_after_start"}, int'(in_ready_m), 1);
        chk({name, "_busy_after_start"}, int'(busy_m), 1);
    endtask

    // Offer one sample until accepted, then watch the W busy cycles that follow.
    task automatic send(input logic [3:0] v, input bit noise, input string name);
        int waited;
        waited   = 0;
        in_valid = 1'b1;
        in_data  = v;
        while (in_ready_m !== 1'b1 && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        if (waited >= 20) chk({name, "_accept_timeout"}, 0, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_data  = 4'd0;
        for (int i = 0; i < TW; i++) begin
            @(negedge clk);
            chk({name, "_no_ready_in_mul"}, int'(in_ready_m), 0);
            if (noise && i < TW - 1) begin
                start    = 1'b1;
                in_valid = 1'b1;
                in_data  = 4'($urandom);
            end
        end
        start    = 1'b0;
        in_valid = 1'b0;
        in_data  = 4'd0;
    endtask

    // Called right after the last sample's send; measures latency from its accept cycle.
    task automatic wait_result(input int exp, input bit restart, input string name);
        int lat;
        lat = TW;
        while (out_valid_m !== 1'b1 && lat < 40) begin
            @(negedge clk);
            lat++;
            if (out_valid_m !== 1'b1) chk({name, "_hold_before_pulse"}, int'(out_data_m), prev_out);
        end
        chk({name, "_latency"}, lat, TW + 2);
        chk({name, "_out_data"}, int'(out_data_m), exp);
        prev_out = exp;
        if (restart) start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk({name, "_pulse_width"}, int'(out_valid_m), 0);
        chk({name, "_hold_1"}, int'(out_data_m), exp);
        if (restart) begin
            chk({name, "_restart_honoured"}, int'(in_ready_m), 1);
        end else begin
            chk({name, "_idle_busy"}, int'(busy_m), 0);
            @(negedge clk);
            chk({name, "_hold_2"}, int'(out_data_m), exp);
        end
    endtask

    task automatic run_vector(input logic [15:0] s, input int n, input int gap,
                              input bit noise, input int exp, input string name);
        logic [15:0] sv;
        sv = s;
        do_start(name);
        for (int i = 0; i < n; i++) begin
            for (int g = 0; g < gap; g++) begin
                @(negedge clk);
                chk({name, "_ready_while_idle_load"}, int'(in_ready_m), 1);
            end
            send(sv[4*i +: 4], noise, name);
        end
        wait_result(exp, 1'b0, name);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl [7];
        int   q [$];
        int   model;
        logic [15:0] rs;
        int   rgap;
        bit   rnoise;

        tbl[0] = '{16'h0043, 2'd0, 1'b0, 10'd25};
        tbl[1] = '{16'hFFFF, 2'd0, 1'b0, 10'd900};
        tbl[2] = '{16'h4321, 2'd3, 1'b0, 10'd30};
        tbl[3] = '{16'h0043, 2'd0, 1'b1, 10'd25};
        tbl[4] = '{16'h0000, 2'd1, 1'b0, 10'd0};
        tbl[5] = '{16'hF00F, 2'd0, 1'b1, 10'd450};
        tbl[6] = '{16'h1111, 2'd1, 1'b1, 10'd4};

        rst_n    = 1'b0;
        start    = 1'b0;
        in_valid = 1'b0;
        in_data  = 4'd0;
        sel2     = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_in_ready", int'(in_ready1), 0);
        chk("reset_out_valid", int'(out_valid1), 0);
        chk("reset_out_data", int'(out_data1), 0);
        chk("reset_busy", int'(busy1), 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_ignores_in_valid_ready", int'(in_ready1), 0);

        for (int v = 0; v < 7; v++) begin
            run_vector(tbl[v].s, 4, int'(tbl[v].gap), tbl[v].noise, int'(tbl[v].exp),
                       $sformatf("tbl%0d", v));
        end

        // Abort a vector mid-multiply, then confirm a clean restart.
        do_start("abort");
        send(4'd3, 1'b0, "abort");
        in_valid = 1'b1;
        in_data  = 4'd4;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("abort_in_ready", int'(in_ready1), 0);
        chk("abort_busy", int'(busy1), 0);
        chk("abort_out_valid", int'(out_valid1), 0);
        chk("abort_out_data", int'(out_data1), 0);
        prev_out = 0;
        @(negedge clk);
        rst_n = 1'b1;
        run_vector(16'h2222, 4, 0, 1'b0, 16, "after_abort");

        for (int r = 0; r < 20; r++) begin
            q.delete();
            model = 0;
            for (int i = 0; i < 4; i++) begin
                q.push_back(int'($urandom_range(0, 15)));
            end
            foreach (q[i]) begin
                rs[4*i +: 4] = 4'(q[i]);
                model += q[i] * q[i];
            end
            rgap   = int'($urandom_range(0, 2));
            rnoise = 1'($urandom);
            run_vector(rs, 4, rgap, rnoise, model, $sformatf("rnd%0d", r));
        end

        // Single-sample configuration, including restart on the out_valid cycle.
        sel2     = 1'b1;
        prev_out = 0;
        @(negedge clk);
        do_start("l1");
        send(4'd9, 1'b0, "l1");
        wait_result(81, 1'b1, "l1");
        send(4'd7, 1'b1, "l1_restart");
        wait_result(49, 1'b0, "l1_restart");
        for (int r = 0; r < 6; r++) begin
            model = int'($urandom_range(0, 15));
            rs    = 16'(model);
            run_vector(rs, 1, int'($urandom_range(0, 2)), 1'($urandom), model * model,
                       $sformatf("l1_rnd%0d", r));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
